atm_teclado_tx: RTL and testbench



---
 rtl/atm_pkg.sv | 53 +++++
 rtl/atm_tx_timer.sv | 38 +++
 rtl/atm_teclado_tx.sv | 232 +++++++++++++++++++++++
 tb/tb_atm_teclado_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM customer-side transaction driver.
package atm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CARD   = 3'd1,
    ST_DIGIT  = 3'd2,
    ST_GAP    = 3'd3,
    ST_AMOUNT = 3'd4,
    ST_WAIT   = 3'd5,
    ST_DONE   = 3'd6
  } atm_state_e;

  localparam int DIGIT_W = 4;

  localparam logic [2:0] RSP_OK_DEPOSITO    = 3'd0;
  localparam logic [2:0] RSP_OK_RETIRO      = 3'd1;
  localparam logic [2:0] RSP_FONDOS_INSUF   = 3'd2;
  localparam logic [2:0] RSP_PIN_INCORRECTO = 3'd3;
  localparam logic [2:0] RSP_BLOQUEO        = 3'd4;
  localparam logic [2:0] RSP_TIMEOUT        = 3'd5;
  localparam logic [2:0] RSP_ABORTADO       = 3'd6;
  localparam logic [2:0] RSP_RESERVED       = 3'd7;

  localparam logic TRANS_DEPOSITO = 1'b0;
  localparam logic TRANS_RETIRO   = 1'b1;

  // Highest-priority raised flag wins; with nothing raised the result is a timeout.
  function automatic logic [2:0] result_code(
    input logic blq,
    input logic pin_bad,
    input logic fondos,
    input logic entregar,
    input logic balance
  );
    logic [2:0] code;
    if (blq) begin
      code = RSP_BLOQUEO;
    end else if (pin_bad) begin
      code = RSP_PIN_INCORRECTO;
    end else if (fondos) begin
      code = RSP_FONDOS_INSUF;
    end else if (entregar) begin
      code = RSP_OK_RETIRO;
    end else if (balance) begin
      code = RSP_OK_DEPOSITO;
    end else begin
      code = RSP_TIMEOUT;
    end
    return code;
  endfunction

endpackage

// File: rtl/atm_tx_timer.sv
// Loadable down-counter; done_o is high during the last cycle of a loaded interval.
module atm_tx_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/atm_teclado_tx.sv
// Plays one ATM transaction (card, PIN digits, amount) onto the controller pins and
// returns an encoded result. Optional ATM_TX_ABORT_EN adds the cmd_abort input.
module atm_teclado_tx
  import atm_pkg::*;
#(
  parameter int MONTO_W    = 32,
  parameter int PIN_DIGITS = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [DIGIT_W*PIN_DIGITS-1:0] cmd_pin,
  input  logic                          cmd_tipo_tarjeta,
  input  logic                          cmd_tipo_trans,
  input  logic [MONTO_W-1:0]            cmd_monto,
`ifdef ATM_TX_ABORT_EN
  input  logic                          cmd_abort,
`endif
  output logic                          tarjeta_recibida,
  output logic                          tipo_de_tarjeta,
  output logic [DIGIT_W-1:0]            digito,
  output logic                          digito_stb,
  output logic                          tipo_trans,
  output logic [MONTO_W-1:0]            monto,
  output logic                          monto_stb,
  input  logic                          balance_actualizado,
  input  logic                          entregar_dinero,
  input  logic                          fondos_insuficientes,
  input  logic                          pin_incorrecto,
  input  logic                          bloqueo,
  output logic                          rsp_valid,
  output logic [2:0]                    rsp_code
);

  localparam int PIN_W   = DIGIT_W * PIN_DIGITS;
  localparam int IDX_W   = $clog2(PIN_DIGITS + 1);
  localparam int TMR_MAX = (GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TMR_GAP     = TMR_W'(GAP_CYCLES);
  localparam logic [TMR_W-1:0] TMR_TIMEOUT = TMR_W'(TIMEOUT);

  atm_state_e          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PIN_W-1:0]    pin_q, pin_d;
  logic                tipo_tarjeta_q, tipo_tarjeta_d;
  logic                tipo_trans_q, tipo_trans_d;
  logic [MONTO_W-1:0]  monto_q, monto_d;
  logic [DIGIT_W-1:0]  digito_q, digito_d;
  logic [2:0]          rsp_code_q, rsp_code_d;
  logic                cmd_ready_q, tarjeta_q, digito_stb_q, monto_stb_q, rsp_valid_q;

  logic                tmr_load_s;
  logic [TMR_W-1:0]    tmr_val_s;
  logic                tmr_done_s;
  logic                abort_s;
  logic                any_flag_s;
  logic                stop_flag_s;
  logic [PIN_W-1:0]    pin_sh_s;
  logic [DIGIT_W-1:0]  digit_s;

`ifdef ATM_TX_ABORT_EN
  assign abort_s = cmd_abort;
`else
  assign abort_s = 1'b0;
`endif

  assign any_flag_s  = balance_actualizado | entregar_dinero | fondos_insuficientes |
                       pin_incorrecto | bloqueo;
  assign stop_flag_s = pin_incorrecto | bloqueo;

  // Most significant nibble goes out first; non-BCD nibbles pass through untouched.
  assign pin_sh_s = pin_q >> (DIGIT_W * (PIN_DIGITS - 1 - int'(idx_q)));
  assign digit_s  = pin_sh_s[DIGIT_W-1:0];

  atm_tx_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .done_o     (tmr_done_s)
  );

  // Next-state, field latching and response-code selection.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    pin_d          = pin_q;
    tipo_tarjeta_d = tipo_tarjeta_q;
    tipo_trans_d   = tipo_trans_q;
    monto_d        = monto_q;
    digito_d       = digito_q;
    rsp_code_d     = RSP_OK_DEPOSITO;
    tmr_load_s     = 1'b0;
    tmr_val_s      = TMR_GAP;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (cmd_valid && cmd_ready_q) begin
          state_d        = ST_CARD;
          pin_d          = cmd_pin;
          tipo_tarjeta_d = cmd_tipo_tarjeta;
          tipo_trans_d   = cmd_tipo_trans;
          monto_d        = cmd_monto;
          tmr_load_s     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CARD: begin
        if (abort_s) begin
          state_d    = ST_DONE;
          rsp_code_d = RSP_ABORTADO;
        end else if (tmr_done_s) begin
          state_d  = ST_DIGIT;
          digito_d = digit_s;
        end else begin
          state_d = ST_CARD;
        end
      end
      ST_DIGIT: begin
        if (abort_s) begin
          state_d    = ST_DONE;
          rsp_code_d = RSP_ABORTADO;
        end else begin
          state_d    = ST_GAP;
          idx_d      = idx_q + IDX_W'(1);
          tmr_load_s = 1'b1;
        end
      end
      // Only the PIN-related flags are meaningful while digits are still going out.
      ST_GAP: begin
        if (stop_flag_s) begin
          state_d    = ST_DONE;
          rsp_code_d = result_code(bloqueo, pin_incorrecto, 1'b0, 1'b0, 1'b0);
        end else if (abort_s) begin
          state_d    = ST_DONE;
          rsp_code_d = RSP_ABORTADO;
        end else if (tmr_done_s) begin
          if (idx_q == IDX_W'(PIN_DIGITS)) begin
            state_d = ST_AMOUNT;
          end else begin
            state_d  = ST_DIGIT;
            digito_d = digit_s;
          end
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_AMOUNT: begin
        if (abort_s) begin
          state_d    = ST_DONE;
          rsp_code_d = RSP_ABORTADO;
        end else begin
          state_d    = ST_WAIT;
          tmr_load_s = 1'b1;
          tmr_val_s  = TMR_TIMEOUT;
        end
      end
      ST_WAIT: begin
        if (any_flag_s) begin
          state_d    = ST_DONE;
          rsp_code_d = result_code(bloqueo, pin_incorrecto, fondos_insuficientes,
                                   entregar_dinero, balance_actualizado);
        end else if (abort_s) begin
          state_d    = ST_DONE;
          rsp_code_d = RSP_ABORTADO;
        end else if (tmr_done_s) begin
          state_d    = ST_DONE;
          rsp_code_d = RSP_TIMEOUT;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched fields and registered outputs; strobes are decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      pin_q          <= '0;
      tipo_tarjeta_q <= 1'b0;
      tipo_trans_q   <= 1'b0;
      monto_q        <= '0;
      digito_q       <= '0;
      rsp_code_q     <= 3'd0;
      cmd_ready_q    <= 1'b1;
      tarjeta_q      <= 1'b0;
      digito_stb_q   <= 1'b0;
      monto_stb_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      pin_q          <= pin_d;
      tipo_tarjeta_q <= tipo_tarjeta_d;
      tipo_trans_q   <= tipo_trans_d;
      monto_q        <= monto_d;
      digito_q       <= digito_d;
      rsp_code_q     <= rsp_code_d;
      cmd_ready_q    <= (state_d == ST_IDLE);
      tarjeta_q      <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      digito_stb_q   <= (state_d == ST_DIGIT);
      monto_stb_q    <= (state_d == ST_AMOUNT);
      rsp_valid_q    <= (state_d == ST_DONE);
    end
  end

  assign cmd_ready        = cmd_ready_q;
  assign tarjeta_recibida = tarjeta_q;
  assign tipo_de_tarjeta  = tipo_tarjeta_q;
  assign digito           = digito_q;
  assign digito_stb       = digito_stb_q;
  assign tipo_trans       = tipo_trans_q;
  assign monto            = monto_q;
  assign monto_stb        = monto_stb_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_code         = rsp_code_q;

endmodule

// File: tb/tb_atm_teclado_tx.sv
// Directed self-checking bench for atm_teclado_tx with a cycle-timed controller model.
module tb_atm_teclado_tx;
  import atm_pkg::*;

  localparam int MONTO_W = 32;
  localparam int TMO     = 64;

  localparam int M_DEP     = 0;
  localparam int M_FUNDS   = 1;
  localparam int M_PIN     = 2;
  localparam int M_PINLAST = 3;
  localparam int M_BOTH    = 4;
  localparam int M_SILENT  = 5;
  localparam int M_EXPIRY  = 6;
  localparam int M_RESET   = 7;
  localparam int M_ABORT   = 8;

  logic clk = 1'b0;
  logic reset;
  logic cmd_valid, cmd_ready;
  logic [15:0] cmd_pin;
  logic cmd_tipo_tarjeta, cmd_tipo_trans;
  logic [MONTO_W-1:0] cmd_monto;
`ifdef ATM_TX_ABORT_EN
  logic cmd_abort;
`endif
  logic tarjeta_recibida, tipo_de_tarjeta, digito_stb, tipo_trans, monto_stb, rsp_valid;
  logic [3:0] digito;
  logic [MONTO_W-1:0] monto;
  logic balance_actualizado, entregar_dinero, fondos_insuficientes, pin_incorrecto, bloqueo;
  logic [2:0] rsp_code;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Transaction records filled by run_txn.
  int c0, dig_n, mstb_n, rsp_n, mstb_cyc, rsp_cyc, rst_cyc;
  int dig_c[4];
  logic [3:0] dig_v[4];
  logic [MONTO_W-1:0] mstb_val;
  logic trans_at_m, tarj_rsp, tarj1, ttar1, ready1, ready_after, rspv_after, hold0, fin;
  logic [2:0] rsp_cd;
  logic [15:0] cur_pin;
  logic cur_card, cur_trans;
  logic [MONTO_W-1:0] cur_amt;

  always #5 clk = ~clk;

  atm_teclado_tx #(
    .MONTO_W(MONTO_W), .PIN_DIGITS(4), .GAP_CYCLES(2), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_pin(cmd_pin), .cmd_tipo_tarjeta(cmd_tipo_tarjeta),
    .cmd_tipo_trans(cmd_tipo_trans), .cmd_monto(cmd_monto),
`ifdef ATM_TX_ABORT_EN
    .cmd_abort(cmd_abort),
`endif
    .tarjeta_recibida(tarjeta_recibida), .tipo_de_tarjeta(tipo_de_tarjeta),
    .digito(digito), .digito_stb(digito_stb), .tipo_trans(tipo_trans),
    .monto(monto), .monto_stb(monto_stb),
    .balance_actualizado(balance_actualizado), .entregar_dinero(entregar_dinero),
    .fondos_insuficientes(fondos_insuficientes), .pin_incorrecto(pin_incorrecto),
    .bloqueo(bloqueo), .rsp_valid(rsp_valid), .rsp_code(rsp_code)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_flags();
    balance_actualizado  = 1'b0;
    entregar_dinero      = 1'b0;
    fondos_insuficientes = 1'b0;
    pin_incorrecto       = 1'b0;
    bloqueo              = 1'b0;
`ifdef ATM_TX_ABORT_EN
    cmd_abort            = 1'b0;
`endif
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_ready"}, cmd_ready, 32'd1);
    check_eq({tag, "_outs"}, {tarjeta_recibida, tipo_de_tarjeta, digito, digito_stb,
                              tipo_trans, monto_stb, rsp_valid, rsp_code}, 32'd0);
    check_eq({tag, "_monto"}, monto, 32'd0);
  endtask

  task automatic run_txn(input logic [15:0] pin, input logic card, input logic trans,
                         input logic [MONTO_W-1:0] amt, input int mode);
    dig_n = 0; mstb_n = 0; rsp_n = 0;
    mstb_cyc = -1000; rsp_cyc = -1000; rst_cyc = -1000;
    mstb_val = '0; trans_at_m = 1'b0; rsp_cd = 3'd7; tarj_rsp = 1'b1; hold0 = 1'b0;
    ready_after = 1'b0; rspv_after = 1'b1; fin = 1'b0;
    cur_pin = pin; cur_card = card; cur_trans = trans; cur_amt = amt;
    check_eq("ready_idle", cmd_ready, 32'd1);
    cmd_valid = 1'b1; cmd_pin = pin; cmd_tipo_tarjeta = card;
    cmd_tipo_trans = trans; cmd_monto = amt;
    c0 = cyc;
    for (int k = 0; k < 250 && !fin; k++) begin
      tick();
      if (k == 0) begin
        tarj1 = tarjeta_recibida; ttar1 = tipo_de_tarjeta; ready1 = cmd_ready;
        cmd_valid = 1'b0; cmd_pin = ~pin; cmd_tipo_tarjeta = ~card;
        cmd_tipo_trans = ~trans; cmd_monto = ~amt;
      end
      if (digito_stb) begin
        if (dig_n < 4) begin
          dig_v[dig_n] = digito;
          dig_c[dig_n] = cyc;
        end
        dig_n++;
      end
      if (dig_n >= 1 && cyc == dig_c[0] + 1) hold0 = (digito == 4'(pin >> 12));
      if (monto_stb) begin
        mstb_n++; mstb_cyc = cyc; mstb_val = monto; trans_at_m = tipo_trans;
      end
      if (rsp_valid) begin
        rsp_n++; rsp_cyc = cyc; rsp_cd = rsp_code; tarj_rsp = tarjeta_recibida;
      end
      if (rsp_n > 0 && cyc == rsp_cyc + 1) begin
        ready_after = cmd_ready; rspv_after = rsp_valid; fin = 1'b1;
      end
      if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
        check_reset_outs("midrst");
        check_eq("midrst_rsp", rsp_n, 32'd0);
        check_eq("midrst_ndig", dig_n, 32'd2);
        reset = 1'b0;
        fin = 1'b1;
      end
      clear_flags();
      case (mode)
        M_DEP: begin
          if (cyc == c0 + 1) fondos_insuficientes = 1'b1;
          if (dig_n == 1 && cyc == dig_c[0]) bloqueo = 1'b1;
          if (mstb_n == 1 && cyc == mstb_cyc) pin_incorrecto = 1'b1;
          if (mstb_n == 1 && cyc == mstb_cyc + 3) balance_actualizado = 1'b1;
        end
        M_FUNDS:   if (mstb_n == 1 && cyc == mstb_cyc + 2) fondos_insuficientes = 1'b1;
        M_PIN:     if (dig_n == 4 && cyc == dig_c[3] + 1) pin_incorrecto = 1'b1;
        M_PINLAST: if (dig_n == 4 && cyc == dig_c[3] + 2) pin_incorrecto = 1'b1;
        M_BOTH: begin
          if (mstb_n == 1 && cyc == mstb_cyc + 1) begin
            bloqueo = 1'b1; pin_incorrecto = 1'b1;
          end
        end
        M_EXPIRY:  if (mstb_n == 1 && cyc == mstb_cyc + TMO) entregar_dinero = 1'b1;
        M_RESET: begin
          if (rst_cyc < 0 && dig_n == 2 && cyc == dig_c[1]) begin
            reset = 1'b1; rst_cyc = cyc;
          end
        end
`ifdef ATM_TX_ABORT_EN
        M_ABORT:   if (dig_n == 3 && cyc == dig_c[2] + 1) cmd_abort = 1'b1;
`endif
        default: ;
      endcase
    end
    clear_flags();
    check_eq("txn_done", fin, 32'd1);
  endtask

  task automatic check_flow(input string tag, input int exp_dig, input int exp_mstb,
                            input logic [2:0] exp_code, input int exp_rsp);
    logic [3:0] nib;
    check_eq({tag, "_tarj_on"}, tarj1, 32'd1);
    check_eq({tag, "_card"}, ttar1, cur_card);
    check_eq({tag, "_busy"}, ready1, 32'd0);
    check_eq({tag, "_ndig"}, dig_n, exp_dig);
    for (int i = 0; i < exp_dig && i < 4; i++) begin
      nib = cur_pin[15 - 4*i -: 4];
      check_eq({tag, "_digit"}, dig_v[i], nib);
      check_eq({tag, "_dig_cyc"}, dig_c[i] - c0, 3 + 3*i);
    end
    check_eq({tag, "_nmstb"}, mstb_n, exp_mstb);
    if (exp_mstb > 0) begin
      check_eq({tag, "_monto"}, mstb_val, cur_amt);
      check_eq({tag, "_trans"}, trans_at_m, cur_trans);
      check_eq({tag, "_mstb_cyc"}, mstb_cyc - c0, 32'd15);
    end
    check_eq({tag, "_nrsp"}, rsp_n, 32'd1);
    check_eq({tag, "_code"}, rsp_cd, exp_code);
    check_eq({tag, "_rsp_cyc"}, rsp_cyc - c0, exp_rsp);
    check_eq({tag, "_tarj_off"}, tarj_rsp, 32'd0);
    check_eq({tag, "_ready_after"}, ready_after, 32'd1);
    check_eq({tag, "_pulse"}, rspv_after, 32'd0);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_pin = 16'h0000; cmd_tipo_tarjeta = 1'b0;
    cmd_tipo_trans = 1'b0; cmd_monto = 32'd0;
    clear_flags();
    repeat (3) tick();
    check_reset_outs("por");
    reset = 1'b0;
    tick();

    run_txn(16'h1234, 1'b1, TRANS_DEPOSITO, 32'd500, M_DEP);
    check_flow("dep", 4, 1, RSP_OK_DEPOSITO, 19);
    check_eq("dep_hold", hold0, 32'd1);

    run_txn(16'h5678, 1'b1, TRANS_RETIRO, 32'd77, M_RESET);

    run_txn(16'h9A0F, 1'b0, TRANS_RETIRO, 32'hFFFF_FFFF, M_EXPIRY);
    check_flow("expiry", 4, 1, RSP_OK_RETIRO, 15 + TMO + 1);

    run_txn(16'h4321, 1'b1, TRANS_RETIRO, 32'd900, M_FUNDS);
    check_flow("funds", 4, 1, RSP_FONDOS_INSUF, 18);

    run_txn(16'h0007, 1'b0, TRANS_RETIRO, 32'd20, M_PIN);
    check_flow("pin", 4, 0, RSP_PIN_INCORRECTO, 14);

    run_txn(16'h8888, 1'b1, TRANS_DEPOSITO, 32'd30, M_PINLAST);
    check_flow("pinlast", 4, 0, RSP_PIN_INCORRECTO, 15);

    run_txn(16'h2468, 1'b0, TRANS_DEPOSITO, 32'd40, M_BOTH);
    check_flow("both", 4, 1, RSP_BLOQUEO, 17);

    run_txn(16'h1357, 1'b1, TRANS_RETIRO, 32'd123456, M_SILENT);
    check_flow("tmo", 4, 1, RSP_TIMEOUT, 15 + TMO + 1);

`ifdef ATM_TX_ABORT_EN
    run_txn(16'h1111, 1'b1, TRANS_RETIRO, 32'd60, M_ABORT);
    check_flow("abort", 3, 0, RSP_ABORTADO, 11);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
